// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Single-port word RAM serving instruction-read, data-read and
//                data-write ports; collisions are serialised W > DR > IR with
//                MEM_WAIT holding the core. Optional MEM_OOR_COUNT_EN adds a
//                saturating out-of-range access counter (OOR_COUNT).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT
`ifdef MEM_OOR_COUNT_EN
    ,
    output logic [15:0] OOR_COUNT
`endif
);

    localparam int unsigned c_idx_w = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_span  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // A write is always the first served, so only the two reads can be pending.
    logic        r_pend_dr;
    logic        r_pend_ir;
    logic [31:0] r_addr_dr;
    logic [31:0] r_addr_ir;

    logic        w_c_w;
    logic        w_c_dr;
    logic        w_c_ir;
    logic [31:0] w_a_dr;
    logic [31:0] w_a_ir;
    logic [1:0]  w_cnt;

    logic        w_sel_w;
    logic        w_sel_dr;
    logic        w_sel_ir;
    logic        w_pend_dr_next;
    logic        w_pend_ir_next;

    logic [31:0]        w_acc_addr;
    logic [31:0]        w_off;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic [31:0]        w_rd_word;

    logic [31:0] r_mem [DEPTH_WORDS];

    always_comb begin
        w_c_w  = 1'b0;
        w_c_dr = r_pend_dr;
        w_c_ir = r_pend_ir;
        w_a_dr = r_addr_dr;
        w_a_ir = r_addr_ir;
        if (r_state == IDLE) begin
            w_c_w  = DATA_WREN;
            w_c_dr = DATA_RDEN;
            w_c_ir = INST_RDEN;
            w_a_dr = DATA_RIADDR;
            w_a_ir = INST_RIADDR;
        end
    end

    assign w_cnt = {1'b0, w_c_w} + {1'b0, w_c_dr} + {1'b0, w_c_ir};

    always_comb begin
        w_state_next   = IDLE;
        w_sel_w        = 1'b0;
        w_sel_dr       = 1'b0;
        w_sel_ir       = 1'b0;
        w_pend_dr_next = 1'b0;
        w_pend_ir_next = 1'b0;
        MEM_WAIT       = 1'b0;
        if (!RST) begin
            w_sel_w        = w_c_w;
            w_sel_dr       = w_c_dr & ~w_c_w;
            w_sel_ir       = w_c_ir & ~w_c_w & ~w_c_dr;
            w_pend_dr_next = w_c_dr & ~w_sel_dr;
            w_pend_ir_next = w_c_ir & ~w_sel_ir;
            if (w_cnt >= 2'd2) begin
                MEM_WAIT     = 1'b1;
                w_state_next = BUSY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend_dr <= 1'b0;
            r_pend_ir <= 1'b0;
            r_addr_dr <= '0;
            r_addr_ir <= '0;
        end else begin
            r_pend_dr <= w_pend_dr_next;
            r_pend_ir <= w_pend_ir_next;
            if (r_state == IDLE) begin
                r_addr_dr <= DATA_RIADDR;
                r_addr_ir <= INST_RIADDR;
            end
        end
    end

    // Single RAM port: address of whichever request wins this cycle.
    assign w_acc_addr = w_sel_w  ? DATA_WADDR :
                        w_sel_dr ? w_a_dr     : w_a_ir;
    assign w_off      = w_acc_addr - ADDR_BASE;
    assign w_in_range = (w_acc_addr >= ADDR_BASE) && ({1'b0, w_off} < c_span);
    assign w_idx      = w_off[c_idx_w+1:2];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'h0;

    always_ff @(posedge CLK) begin
        if (w_sel_w && w_in_range) begin
            r_mem[w_idx] <= DATA_WDATA;
        end
    end

    // RVALID survives stall cycles so the core still sees it at its release edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_RVALID <= 1'b0;
            DATA_RDATA  <= '0;
            DATA_ROADDR <= '0;
            INST_RVALID <= 1'b0;
            INST_RDATA  <= '0;
            INST_ROADDR <= '0;
        end else begin
            if (w_sel_dr) begin
                DATA_RVALID <= 1'b1;
                DATA_RDATA  <= w_rd_word;
                DATA_ROADDR <= w_a_dr;
            end else if (!MEM_WAIT) begin
                DATA_RVALID <= 1'b0;
            end
            if (w_sel_ir) begin
                INST_RVALID <= 1'b1;
                INST_RDATA  <= w_rd_word;
                INST_ROADDR <= w_a_ir;
            end else if (!MEM_WAIT) begin
                INST_RVALID <= 1'b0;
            end
        end
    end

`ifdef MEM_OOR_COUNT_EN
    logic w_any_sel;
    assign w_any_sel = w_sel_w | w_sel_dr | w_sel_ir;

    always_ff @(posedge CLK) begin
        if (RST) begin
            OOR_COUNT <= '0;
        end else if (w_any_sel && !w_in_range && (OOR_COUNT != 16'hFFFF)) begin
            OOR_COUNT <= OOR_COUNT + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard bench for mem_responder: directed scenarios plus
//                random request groups checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
`ifdef MEM_OOR_COUNT_EN
    logic [15:0] OOR_COUNT;
`endif

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_BASE  (BASE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .INST_RDEN  (INST_RDEN),
        .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR),
        .INST_RVALID(INST_RVALID),
        .INST_RDATA (INST_RDATA),
        .DATA_RDEN  (DATA_RDEN),
        .DATA_RIADDR(DATA_RIADDR),
        .DATA_ROADDR(DATA_ROADDR),
        .DATA_RVALID(DATA_RVALID),
        .DATA_RDATA (DATA_RDATA),
        .DATA_WREN  (DATA_WREN),
        .DATA_WADDR (DATA_WADDR),
        .DATA_WDATA (DATA_WDATA),
        .MEM_WAIT   (MEM_WAIT)
`ifdef MEM_OOR_COUNT_EN
        ,
        .OOR_COUNT  (OOR_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } resp_t;

    resp_t       iq[$];
    resp_t       dq[$];
    bit          wq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];
    int unsigned model_oor = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && ({1'b0, a - BASE} < (33'(DEPTH) << 2));
    endfunction

    function automatic int word_index(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        return model_mem[word_index(a)];
    endfunction

    task automatic note_oor();
        if (model_oor < 32'd65535) model_oor++;
    endtask

    // One core cycle: present the requests and record the stall the core should see.
    task automatic drive(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                         input bit dr, input logic [31:0] dra,
                         input bit ir, input logic [31:0] ira, input bit ew);
        @(posedge CLK);
        #1;
        DATA_WREN   = w;
        DATA_WADDR  = wa;
        DATA_WDATA  = wd;
        DATA_RDEN   = dr;
        DATA_RIADDR = dra;
        INST_RDEN   = ir;
        INST_RIADDR = ira;
        wq.push_back(ew);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // A request group is served in W, DR, IR order; the held core re-presents it until released.
    task automatic group(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                         input bit dr, input logic [31:0] dra,
                         input bit ir, input logic [31:0] ira);
        int    n;
        resp_t r;
        n = int'(w) + int'(dr) + int'(ir);
        if (n >= 2) idle();
        if (w) begin
            if (in_range(wa)) model_mem[word_index(wa)] = wd;
            else note_oor();
        end
        if (dr) begin
            r.addr = dra;
            r.data = model_read(dra);
            dq.push_back(r);
            if (!in_range(dra)) note_oor();
        end
        if (ir) begin
            r.addr = ira;
            r.data = model_read(ira);
            iq.push_back(r);
            if (!in_range(ira)) note_oor();
        end
        if (n <= 1) begin
            drive(w, wa, wd, dr, dra, ir, ira, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) drive(w, wa, wd, dr, dra, ir, ira, i < n - 1);
            idle();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) return 32'h0000_4000 + 32'($urandom_range(0, 15) << 2);
            return 32'hFFFF_FF00 + 32'($urandom_range(0, 63));
        end
        return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    // Monitor: a response is consumed at the first non-stalled cycle it is visible.
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge CLK);
            if (wq.size() > 0) chk("mem_wait", {31'b0, MEM_WAIT}, {31'b0, wq.pop_front()});
            if (!RST && !MEM_WAIT) begin
                if (DATA_RVALID) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_extra_rvalid actual=1 expected=0");
                    end else begin
                        r = dq.pop_front();
                        chk("data_rdata", DATA_RDATA, r.data);
                        chk("data_roaddr", DATA_ROADDR, r.addr);
                    end
                end
                if (INST_RVALID) begin
                    if (iq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst_extra_rvalid actual=1 expected=0");
                    end else begin
                        r = iq.pop_front();
                        chk("inst_rdata", INST_RDATA, r.data);
                        chk("inst_roaddr", INST_ROADDR, r.addr);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        RST         = 1'b1;
        DATA_WREN   = 1'b0;
        DATA_WADDR  = '0;
        DATA_WDATA  = '0;
        DATA_RDEN   = 1'b0;
        DATA_RIADDR = '0;
        INST_RDEN   = 1'b0;
        INST_RIADDR = '0;
        repeat (3) idle();
        chk("rst_inst_rvalid", {31'b0, INST_RVALID}, 32'h0);
        chk("rst_data_rvalid", {31'b0, DATA_RVALID}, 32'h0);
        chk("rst_inst_rdata", INST_RDATA, 32'h0);
        chk("rst_data_rdata", DATA_RDATA, 32'h0);
        chk("rst_inst_roaddr", INST_ROADDR, 32'h0);
        chk("rst_data_roaddr", DATA_ROADDR, 32'h0);
        chk("rst_mem_wait", {31'b0, MEM_WAIT}, 32'h0);
        RST = 1'b0;

        for (int i = 0; i < 16; i++)
            group(1'b1, 32'(i * 4), (i == 0) ? 32'h0000_0013 : $urandom, 1'b0, 32'h0, 1'b0, 32'h0);

        // Uncontended write then read.
        group(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0);
        group(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        idle();

        // Three-way collision with read-after-write.
        group(1'b1, 32'h20, 32'h0000_1234, 1'b1, 32'h20, 1'b1, 32'h0);

        // Out of range read and dropped write, then confirm word 0 untouched.
        group(1'b0, 32'h0, 32'h0, 1'b1, 32'h4000, 1'b0, 32'h0);
        group(1'b1, 32'h4000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
`ifdef MEM_OOR_COUNT_EN
        chk("oor_count_directed", {16'h0, OOR_COUNT}, model_oor);
`endif
        group(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        idle();

        // Streaming instruction fetch.
        for (int i = 0; i < 3; i++) group(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(i * 4));
        idle();

        // Reset while the second request of a collision is still pending.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 32'hC, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        wq.push_back(1'b0);
        @(posedge CLK);
        #1;
        RST         = 1'b0;
        DATA_RDEN   = 1'b0;
        INST_RDEN   = 1'b0;
        wq.push_back(1'b0);
        chk("midrst_data_rvalid", {31'b0, DATA_RVALID}, 32'h0);
        chk("midrst_inst_rvalid", {31'b0, INST_RVALID}, 32'h0);
        group(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        group(1'b1, 32'h24, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 32'h24);

        for (int g = 0; g < 250; g++) begin
            a0 = rand_addr();
            a1 = rand_addr();
            a2 = rand_addr();
            group(1'($urandom_range(0, 1)), a0, $urandom, 1'($urandom_range(0, 1)), a1,
                  1'($urandom_range(0, 1)), a2);
        end

        repeat (3) idle();
        chk("data_queue_empty", 32'(dq.size()), 32'h0);
        chk("inst_queue_empty", 32'(iq.size()), 32'h0);
`ifdef MEM_OOR_COUNT_EN
        chk("oor_count_final", {16'h0, OOR_COUNT}, model_oor);
`endif
        @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's instruction-read, data-read and data-write ports. It is backed by a single-port word RAM, so only one access is served per cycle. When requests collide in the same cycle, it serialises them by fixed priority and asserts MEM_WAIT so the core pipeline holds. It sits where the MMU attaches to the core and serves as the simulation and FPGA on-chip memory.

Parameters:
DEPTH_WORDS, 4096, RAM size in 32-bit words; must be a power of two.
ADDR_BASE, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-high reset
INST_RDEN  input  1  instruction read request
INST_RIADDR  input  32  instruction byte address
INST_ROADDR  output  32  address of the returned instruction word
INST_RVALID  output  1  instruction response valid
INST_RDATA  output  32  instruction word
DATA_RDEN  input  1  data read request
DATA_RIADDR  input  32  data read byte address
DATA_ROADDR  output  32  address of the returned data word
DATA_RVALID  output  1  data response valid
DATA_RDATA  output  32  data word
DATA_WREN  input  1  data write request (full word)
DATA_WADDR  input  32  data write byte address
DATA_WDATA  input  32  write data
MEM_WAIT  output  1  stall request to the core (combinational)

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset values:
  - state = IDLE; all RVALID = 0; all RDATA/ROADDR = 0; MEM_WAIT = 0 (forced low while RST = 1).
  - RAM contents are not reset.
- Address mapping:
  - index = (addr - ADDR_BASE) >> 2; addr[1:0] is ignored.
  - An address is out of range when addr < ADDR_BASE or (addr - ADDR_BASE) >= DEPTH_WORDS*4.
  - Out-of-range reads return 0 with RVALID still asserted; out-of-range writes are dropped.
- Priority, highest first: data write (W), data read (DR), instruction read (IR).
- Service cycle for a read: the RAM is read at that edge. ROADDR takes the request address and RDATA the word, both visible from the next cycle.
- IDLE state:
  - Sample the request set R = {WREN, DRDEN, IRDEN}.
  - |R| = 0: nothing happens.
  - |R| = 1: serve it this cycle; MEM_WAIT = 0; stay IDLE.
  - |R| >= 2: MEM_WAIT = 1 combinationally in this cycle. Serve the highest-priority request. Latch the remaining requests with their addresses and WDATA. Go to BUSY.
- BUSY state:
  - Serve the highest remaining latched request, one per cycle.
  - MEM_WAIT = 1 while more than one request remains, including the one served this cycle. MEM_WAIT = 0 in the cycle serving the last one; return to IDLE at that edge.
  - Live inputs are ignored in BUSY. The held core re-presents the same requests, which are already latched.
- Read-after-write within one colliding group returns the newly written word, because W is served first.
- RVALID per channel:
  - Set at the channel's service edge.
  - Cleared at the first later edge where MEM_WAIT = 0 and that channel is not served again, so a stalled core still sees it at its releasing edge.
  - Back-to-back single reads keep RVALID high with the data updating every cycle.
- Latencies:
  - Uncontended read: data at t+1.
  - 2-way collision: second request served at t+1.
  - 3-way collision: IR served at t+2, IR data at t+3.
- Reset mid-BUSY: pending latched requests are discarded, no further RVALID is raised, and any write not yet served is lost.

Optional Feature:
MEM_OOR_COUNT_EN
- Defined:
  - Adds output OOR_COUNT [15:0], reset 0.
  - Increments by 1 per served out-of-range access (read or write) and saturates at 16'hFFFF.
  - Counts the service event, not the raw request, so held duplicates are not counted.
- Undefined: no port and no counter logic; out-of-range behaviour is otherwise identical.

Test Plan:
1. Write then read, uncontended: WREN addr 0x10 data 0xDEADBEEF; next cycle DRDEN 0x10 -> DATA_RVALID = 1, DATA_RDATA = 0xDEADBEEF, DATA_ROADDR = 0x10 one cycle later; MEM_WAIT never asserted.
2. Three-way collision: W 0x20 = 0x1234, DR 0x20, IR 0x0 (RAM[0] = 0x00000013) at t -> MEM_WAIT = 1 at t and t+1, 0 at t+2. DATA_RDATA = 0x1234 from t+2. INST_RDATA = 0x13 at t+3. Exactly one write occurs.
3. Held duplicates: the core holds all three requests during MEM_WAIT -> no extra writes and no extra RVALIDs; INST_RVALID remains high until the first non-wait edge.
4. Out of range with DEPTH_WORDS = 4096: DRDEN 0x4000 -> DATA_RVALID = 1, DATA_RDATA = 0. WREN 0x4000 -> RAM unchanged. With MEM_OOR_COUNT_EN defined -> OOR_COUNT = 2.
5. Reset mid-BUSY: 2-way collision at t, RST = 1 at t+1 -> no RVALID at t+2, MEM_WAIT = 0, state IDLE.
6. Streaming fetch: IRDEN every cycle at addresses 0, 4, 8 -> INST_RVALID continuously 1 and INST_ROADDR = 0, 4, 8 on consecutive cycles.
